// File: rtl/pulse_width_meter.sv
// Measures the width, in clock cycles, of the next complete high pulse on `in`
// after a soc/eoc handshake; the result saturates at 2^WIDTH-1 and sets ovf.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | eoc=1, last result valid; soc=1 starts a transaction
// S_ACK    | eoc=0, waiting for the consumer to drop soc
// S_ARM    | waiting for in=0 so a pulse already in progress is discarded
// S_WAITH  | waiting for the rising edge of the pulse to measure
// S_COUNT  | counting high cycles; first low sample publishes the result
module pulse_width_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soc,
  input  logic             in,
  output logic             eoc,
  output logic [WIDTH-1:0] numero,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_ARM,
    S_WAITH,
    S_COUNT
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic             sat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      eoc     <= 1'b1;
      numero  <= '0;
      ovf     <= 1'b0;
      counter <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (soc) begin
            eoc   <= 1'b0;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!soc) state <= S_ARM;
        end
        S_ARM: begin
          if (!in) begin
            sat   <= 1'b0;
            state <= S_WAITH;
          end
        end
        S_WAITH: begin
          if (in) begin
            counter <= WIDTH'(1);
            state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (in) begin
            // Hold at the ceiling instead of wrapping; remember that we clipped.
            if (counter == CNT_MAX) sat <= 1'b1;
            else                    counter <= counter + 1'b1;
          end else begin
            numero <= counter;
            ovf    <= sat;
            eoc    <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: begin
          eoc   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter: directed scenarios plus random
// transactions checked against a pulse-length reference model.
module tb_pulse_width_meter;

  localparam int W      = 8;
  localparam int MAXVAL = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         soc;
  logic         in;
  logic         eoc;
  logic [W-1:0] numero;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the result the consumer last read.
  int last_num = 0;
  int last_ovf = 0;

  always #5 clock = ~clock;

  pulse_width_meter #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .soc    (soc),
    .in     (in),
    .eoc    (eoc),
    .numero (numero),
    .ovf    (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check_busy(input string tag);
    check({tag, "_eoc"}, 32'(eoc), 32'd0);
    check({tag, "_numero_hold"}, 32'(numero), 32'(last_num));
    check({tag, "_ovf_hold"}, 32'(ovf), 32'(last_ovf));
  endtask

  // One transaction: optional pulse already high at soc, a low gap, then an
  // n-cycle pulse. With chain set, soc is raised before eoc comes back.
  task automatic run_txn(input int pre_high, input int extra_high, input int low_gap,
                         input int n, input bit chain);
    bit got;
    int exp_num;
    int exp_ovf;
    if (pre_high != 0) in = 1'b1;
    soc = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (eoc == 1'b0) got = 1'b1;
    end
    check("handshake_ack", 32'(got), 32'd1);
    soc = 1'b0;
    for (int k = 0; k < extra_high; k++) begin
      step();
      check_busy("pre_pulse");
    end
    in = 1'b0;
    for (int k = 0; k < low_gap; k++) begin
      step();
      check_busy("low_gap");
    end
    in = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      check_busy("pulse_high");
    end
    in = 1'b0;
    if (chain) soc = 1'b1;
    step();
    exp_num = (n > MAXVAL) ? MAXVAL : n;
    exp_ovf = (n > MAXVAL) ? 1 : 0;
    check("eoc_rise", 32'(eoc), 32'd1);
    check("numero", 32'(numero), 32'(exp_num));
    check("ovf", 32'(ovf), 32'(exp_ovf));
    last_num = exp_num;
    last_ovf = exp_ovf;
    if (!chain) begin
      step();
      check("eoc_stays_idle", 32'(eoc), 32'd1);
      check("numero_stays", 32'(numero), 32'(last_num));
    end
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    soc   = 1'b0;
    in    = 1'b0;
    step();
    step();
    check("reset_eoc", 32'(eoc), 32'd1);
    check("reset_numero", 32'(numero), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_eoc", 32'(eoc), 32'd1);
    end

    // Basic 5-cycle pulse
    run_txn(0, 0, 3, 5, 1'b0);
    // Partial pulse discarded, then 7-cycle pulse
    run_txn(1, 4, 2, 7, 1'b0);
    // Saturation then recovery
    run_txn(0, 0, 2, 300, 1'b0);
    run_txn(0, 0, 2, 2, 1'b0);
    // Boundary around the ceiling
    run_txn(0, 0, 2, MAXVAL, 1'b0);
    run_txn(0, 0, 2, MAXVAL + 1, 1'b0);

    // Reset in the middle of counting
    soc = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (eoc == 1'b0) got = 1'b1;
    end
    check("mid_reset_ack", 32'(got), 32'd1);
    soc = 1'b0;
    step();
    step();
    in = 1'b1;
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    step();
    check("mid_reset_eoc", 32'(eoc), 32'd1);
    check("mid_reset_numero", 32'(numero), 32'd0);
    check("mid_reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    in = 1'b0;
    last_num = 0;
    last_ovf = 0;
    step();
    run_txn(0, 0, 2, 4, 1'b0);

    // Back-to-back handshakes
    run_txn(0, 0, 2, 1, 1'b1);
    run_txn(0, 0, 2, 9, 1'b0);

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      int n;
      int pre;
      int extra;
      int gap;
      bit chain;
      int idle;
      n     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262))
                                          : int'($urandom_range(1, 40));
      pre   = int'($urandom_range(0, 1));
      extra = int'($urandom_range(0, 3));
      gap   = int'($urandom_range(2, 5));
      chain = ($urandom_range(0, 3) == 0);
      run_txn(pre, extra, gap, n, chain);
      if (!chain) begin
        idle = int'($urandom_range(0, 2));
        for (int k = 0; k < idle; k++) begin
          step();
          check("rand_idle_eoc", 32'(eoc), 32'd1);
        end
      end
    end

    soc = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Responder end of the soc/eoc start-of-conversion handshake.
- A consumer raises soc to request a measurement. The block then measures the width, in clock cycles, of the next complete high pulse on `in`.
- It presents the width on `numero` and raises eoc.
- It is the measuring counterpart of the pulse generators on the same handshake, so a generator driving `in` can be checked by reading back `numero`.

Parameters:
- WIDTH, 8, width of `numero` and the internal counter.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clock.
- soc  input  1  start of conversion from the consumer.
- eoc  output  1  end of conversion; 1 = idle/result valid, 0 = busy.
- in  input  1  pulse to measure; synchronous to clock, no synchroniser inside.
- numero  output  WIDTH  measured high-pulse width in cycles; saturates.
- ovf  output  1  1 = last measurement saturated.

Behaviour:
- Reset (reset=1 at posedge):
  - eoc=1, numero=0, ovf=0, counter=0, state=S_IDLE.
  - Overrides every other condition and aborts any measurement in progress.
- All outputs are registered.
- Handshake rules:
  - Consumer raises soc while eoc=1.
  - Block drops eoc.
  - Consumer drops soc.
  - Block measures, then raises eoc with `numero`/`ovf` valid.
  - Consumer reads while eoc=1.
- States:
  - S_IDLE: eoc=1; `numero`/`ovf` hold the last result. soc=1 -> S_ACK with eoc<=0; else stay.
  - S_ACK: eoc=0; wait for soc=0 -> S_ARM. Counter is not touched.
  - S_ARM: wait for in=0 -> S_WAITH. A pulse already high when S_ARM is entered is discarded, so only complete pulses are measured.
  - S_WAITH: on in=1, counter<=1 -> S_COUNT; else stay.
  - S_COUNT, each posedge with in=1: counter<=counter+1, saturating at 2^WIDTH-1; a saturating increment sets internal sat flag.
  - S_COUNT, first posedge with in=0: numero<=counter, ovf<=sat, eoc<=1 -> S_IDLE.
- Latency:
  - A pulse high for N sampled edges yields numero=N.
  - eoc rises on the first posedge that samples in=0 after the pulse, i.e. one clock after the pulse's falling edge as seen at the register.
- Width rules:
  - numero=0 only after reset; a valid measurement is >=1.
  - No wrap-around: N >= 2^WIDTH gives numero=2^WIDTH-1, ovf=1.
  - sat is cleared on entry to S_WAITH.
- soc held 1 in S_IDLE right after eoc rises starts a new transaction on that edge.
- soc toggling while in S_ARM/S_WAITH/S_COUNT is ignored; the measurement completes.
- `numero`/`ovf` change only on the edge where eoc rises, or on reset. They are stable throughout S_ACK..S_COUNT, i.e. the old result stays visible while busy.
- No timeout: the block waits indefinitely for `in` activity. Reset is the only abort.

Test Plan:
1. Reset: assert reset 2 cycles -> eoc=1, numero=0, ovf=0; soc=0 for 10 cycles -> eoc stays 1.
2. Basic measurement:
   - Stimulus: soc=1 until eoc=0, then soc=0; in low 3 cycles, high 5 cycles, low.
   - Response: numero=5, ovf=0; eoc rises exactly one clock after in falls and stays 1.
3. Partial pulse discarded:
   - Stimulus: in already high at soc; stays high 4 more cycles, low 2, then high 7, low.
   - Response: numero=7, not 4 or 11.
4. Saturation (WIDTH=8): in high 300 cycles -> numero=255, ovf=1. Next transaction with a 2-cycle pulse -> numero=2, ovf=0.
5. Reset mid-measurement:
   - Stimulus: reset asserted after 3 high cycles in S_COUNT.
   - Response: eoc=1, numero=0 on the next edge. A new transaction with a 4-cycle pulse gives numero=4.
6. Back-to-back handshakes:
   - Stimulus: 1-cycle pulse, then soc raised on the same edge eoc rises, then a 9-cycle pulse.
   - Response: numero=1 then numero=9; numero=1 held constant throughout the second transaction until eoc rises.
